key_debouncer: RTL and testbench
================================

KEY_DEBOUNCER -- requirements
Module: key_debouncer

Interface
REQ-001 Parameter N_KEYS, default 4: number of independent push-button channels.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000000 (20 ms at 50 MHz): stable-level time required to accept a press or a release; legal range 1 or more.
REQ-003 Parameter LONG_CYCLES, default 50000000 (1 s): held time before long-press; legal range 1 or more.
REQ-004 Parameter REPEAT_CYCLES, default 10000000 (200 ms): auto-repeat period after long-press; legal range 1 or more.
REQ-005 CLOCK_50  input  1  sole clock; all logic rising-edge.
REQ-006 RST_N  input  1  asynchronous, active-low reset.
REQ-007 KEY  input  N_KEYS  raw board buttons, asynchronous to CLOCK_50, active-low (0 = pressed).
REQ-008 pressed  output  N_KEYS  debounced level, 1 = key held.
REQ-009 press_pulse  output  N_KEYS  1-cycle strobe when a press is accepted.
REQ-010 release_pulse  output  N_KEYS  1-cycle strobe when a release is accepted.
REQ-011 long_pulse  output  N_KEYS  1-cycle strobe when a press has been held LONG_CYCLES.
REQ-012 repeat_pulse  output  N_KEYS  1-cycle strobe every REPEAT_CYCLES while in long-press.

Function
REQ-013 Each KEY bit SHALL pass through a 2-flop synchronizer; its inverted output k (1 = pressed) drives that channel's FSM.
REQ-014 Each channel SHALL have one counter cnt, of width $clog2 of the largest timing parameter, and the states IDLE, PRESS_WAIT, HELD, LONG_HELD and RELEASE_WAIT.
REQ-015 IDLE: if k=1, go to PRESS_WAIT with cnt=0.
REQ-016 PRESS_WAIT, k=0: return to IDLE with no pulse (glitch rejected).
REQ-017 PRESS_WAIT, k=1 and cnt=DEBOUNCE_CYCLES-1: go to HELD, assert press_pulse and set cnt=0; otherwise increment cnt.
REQ-018 HELD, k=0: go to RELEASE_WAIT with cnt=0.
REQ-019 HELD, k=1 and cnt=LONG_CYCLES-1: go to LONG_HELD, assert long_pulse and set cnt=0; otherwise increment cnt.
REQ-020 LONG_HELD, k=0: go to RELEASE_WAIT with cnt=0.
REQ-021 LONG_HELD, k=1 and cnt=REPEAT_CYCLES-1: assert repeat_pulse and set cnt=0, wrapping indefinitely; otherwise increment cnt.
REQ-022 RELEASE_WAIT, k=1: return to HELD with cnt=0 (bounce on release); the long-press timing restarts and no pulse is issued.
REQ-023 RELEASE_WAIT, k=0 and cnt=DEBOUNCE_CYCLES-1: go to IDLE and assert release_pulse; otherwise increment cnt.
REQ-024 pressed SHALL be 1 exactly in HELD, LONG_HELD and RELEASE_WAIT.
REQ-025 All outputs SHALL be registered; every pulse SHALL be high for exactly one cycle, in the cycle after the transition edge.
REQ-026 Latency: with KEY low and stable before edge 1, press_pulse SHALL be high after edge DEBOUNCE_CYCLES+3.
REQ-027 Channels SHALL be fully independent; simultaneous events on different keys SHALL each produce their own pulses in the same cycle.
REQ-028 press_pulse and release_pulse of one channel SHALL never be high in the same cycle.

Reset
REQ-029 While RST_N=0, all states SHALL be IDLE, all cnt SHALL be 0, synchronizer flops SHALL hold 1 (released) and all outputs SHALL be 0, regardless of KEY.
REQ-030 Reset asserted mid-press SHALL produce no release_pulse; after RST_N rises, a key still held SHALL be re-debounced from IDLE.

Structure
REQ-031 Package key_debouncer_pkg SHALL hold the state enum and the default timing constants.
REQ-032 Sub-module key_debounce_channel (synchronizer, FSM and counter for one key) SHALL be instantiated N_KEYS times via generate.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=5)
REQ-033 KEY[0] held low from edge 1 -> press_pulse[0] high after edge 7 only; pressed[0]=1 from edge 7 onward.
REQ-034 KEY[1] low for 3 cycles then high -> no pulses; pressed[1] stays 0.
REQ-035 KEY[0] held low for 60 cycles -> one press_pulse, long_pulse 20 cycles later, then repeat_pulse every 5 cycles; release -> release_pulse 4+3 edges after KEY rises.
REQ-036 Release bounce (KEY high 2 cycles, low 1, then high) -> no release_pulse until 4 stable high cycles; then exactly one.
REQ-037 RST_N pulsed low while pressed[2]=1 -> all outputs 0 immediately (asynchronous), no release_pulse; key still low -> new press_pulse 7 edges after RST_N rises.
REQ-038 KEY[0] and KEY[3] fall in the same cycle -> press_pulse[0] and press_pulse[3] high in the same cycle.

Source files
------------

// File: rtl/key_debouncer_pkg.sv
// key_debouncer_pkg: shared state encoding, default timing constants and counter sizing
package key_debouncer_pkg;
   typedef enum logic [2:0] {IDLE, PRESS_WAIT, HELD, LONG_HELD, RELEASE_WAIT} state_e;
   localparam int DEF_N_KEYS          = 4;
   localparam int DEF_DEBOUNCE_CYCLES = 1000000;
   localparam int DEF_LONG_CYCLES     = 50000000;
   localparam int DEF_REPEAT_CYCLES   = 10000000;
   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      m = (m > c) ? m : c;
      return (m > 1) ? $clog2(m) : 1;
   endfunction
endpackage

// File: rtl/key_debouncer_if.sv
// key_debouncer_if: raw key inputs and debounced level/strobe outputs
interface key_debouncer_if #(parameter int N_KEYS = key_debouncer_pkg::DEF_N_KEYS);
   logic [N_KEYS-1:0] KEY;
   logic [N_KEYS-1:0] pressed;
   logic [N_KEYS-1:0] press_pulse;
   logic [N_KEYS-1:0] release_pulse;
   logic [N_KEYS-1:0] long_pulse;
   logic [N_KEYS-1:0] repeat_pulse;
   modport master (output KEY, input pressed, press_pulse, release_pulse, long_pulse, repeat_pulse);
   modport slave  (input KEY, output pressed, press_pulse, release_pulse, long_pulse, repeat_pulse);
endinterface

// File: rtl/key_debouncer_channel.sv
// key_debounce_channel: synchronizer, press/long/repeat FSM and shared counter for one key
module key_debounce_channel
   import key_debouncer_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
   parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic key_i,
   output logic pressed_o,
   output logic press_pulse_o,
   output logic release_pulse_o,
   output logic long_pulse_o,
   output logic repeat_pulse_o
);
   localparam int CW = cnt_width(DEBOUNCE_CYCLES, LONG_CYCLES, REPEAT_CYCLES);
   localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
   localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);
   logic [1:0]    sync_q;
   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          press_d, release_d, long_d, repeat_d;
   logic          k;
   // sync flops idle at 1 so a key held through reset is re-debounced afterwards
   assign k = ~sync_q[1];
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q          <= 2'b11;
         state_q         <= IDLE;
         cnt_q           <= '0;
         pressed_o       <= 1'b0;
         press_pulse_o   <= 1'b0;
         release_pulse_o <= 1'b0;
         long_pulse_o    <= 1'b0;
         repeat_pulse_o  <= 1'b0;
      end else begin
         sync_q          <= {sync_q[0], key_i};
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         pressed_o       <= (state_d == HELD) || (state_d == LONG_HELD) || (state_d == RELEASE_WAIT);
         press_pulse_o   <= press_d;
         release_pulse_o <= release_d;
         long_pulse_o    <= long_d;
         repeat_pulse_o  <= repeat_d;
      end
   end
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + 1'b1;
      press_d   = 1'b0;
      release_d = 1'b0;
      long_d    = 1'b0;
      repeat_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (k) state_d = PRESS_WAIT;
         end
         PRESS_WAIT: begin
            if (!k) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == DEB_LAST) begin
               state_d = HELD;
               cnt_d   = '0;
               press_d = 1'b1;
            end
         end
         HELD: begin
            if (!k) begin
               state_d = RELEASE_WAIT;
               cnt_d   = '0;
            end else if (cnt_q == LONG_LAST) begin
               state_d = LONG_HELD;
               cnt_d   = '0;
               long_d  = 1'b1;
            end
         end
         LONG_HELD: begin
            if (!k) begin
               state_d = RELEASE_WAIT;
               cnt_d   = '0;
            end else if (cnt_q == REP_LAST) begin
               cnt_d    = '0;
               repeat_d = 1'b1;
            end
         end
         RELEASE_WAIT: begin
            if (k) begin
               state_d = HELD;
               cnt_d   = '0;
            end else if (cnt_q == DEB_LAST) begin
               state_d   = IDLE;
               cnt_d     = '0;
               release_d = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end
endmodule

// File: rtl/key_debouncer.sv
// key_debouncer: N_KEYS independent push-button debouncers with long-press and auto-repeat
module key_debouncer
   import key_debouncer_pkg::*;
#(
   parameter int N_KEYS          = DEF_N_KEYS,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
   parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
   input logic            CLOCK_50,
   input logic            RST_N,
   key_debouncer_if.slave bus
);
   logic [N_KEYS-1:0] pressed, press_pulse, release_pulse, long_pulse, repeat_pulse;
   for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
      key_debounce_channel #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .LONG_CYCLES    (LONG_CYCLES),
         .REPEAT_CYCLES  (REPEAT_CYCLES)
      ) u_ch (
         .clk_i          (CLOCK_50),
         .rst_ni         (RST_N),
         .key_i          (bus.KEY[g]),
         .pressed_o      (pressed[g]),
         .press_pulse_o  (press_pulse[g]),
         .release_pulse_o(release_pulse[g]),
         .long_pulse_o   (long_pulse[g]),
         .repeat_pulse_o (repeat_pulse[g])
      );
   end
   assign bus.pressed       = pressed;
   assign bus.press_pulse   = press_pulse;
   assign bus.release_pulse = release_pulse;
   assign bus.long_pulse    = long_pulse;
   assign bus.repeat_pulse  = repeat_pulse;
endmodule

// File: tb/tb_key_debouncer.sv
// tb_key_debouncer: directed scenarios with hand-computed edge timing (DEBOUNCE=4, LONG=20, REPEAT=5)
module tb_key_debouncer;
   logic CLOCK_50 = 1'b0;
   logic RST_N    = 1'b1;
   int   vec  = 0;
   int   errs = 0;
   key_debouncer_if #(.N_KEYS(4)) bus ();
   key_debouncer #(
      .N_KEYS(4), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(20), .REPEAT_CYCLES(5)
   ) dut (
      .CLOCK_50(CLOCK_50),
      .RST_N   (RST_N),
      .bus     (bus)
   );
   always #5 CLOCK_50 = ~CLOCK_50;
   task automatic tick();
      @(posedge CLOCK_50);
      #1;
   endtask
   task automatic test_reset();
      bus.KEY = 4'b0000;
      #2 RST_N = 1'b0;
      #1;
      vec++;
      if ({bus.pressed, bus.press_pulse, bus.release_pulse, bus.long_pulse, bus.repeat_pulse} !== 20'h0) begin
         errs++;
         $display("FAIL reset_async: outputs=%h want 0", {bus.pressed, bus.press_pulse, bus.release_pulse, bus.long_pulse, bus.repeat_pulse});
      end
      for (int t = 1; t <= 3; t++) begin
         tick();
         vec++;
         if ({bus.pressed, bus.press_pulse, bus.release_pulse, bus.long_pulse, bus.repeat_pulse} !== 20'h0) begin
            errs++;
            $display("FAIL reset_hold t=%0d: outputs=%h want 0", t, {bus.pressed, bus.press_pulse, bus.release_pulse, bus.long_pulse, bus.repeat_pulse});
         end
      end
      bus.KEY = 4'b1111;
      tick();
      tick();
      RST_N = 1'b1;
      for (int t = 1; t <= 8; t++) begin
         tick();
         vec++;
         if ({bus.pressed, bus.press_pulse, bus.release_pulse, bus.long_pulse, bus.repeat_pulse} !== 20'h0) begin
            errs++;
            $display("FAIL reset_idle t=%0d: outputs=%h want 0", t, {bus.pressed, bus.press_pulse, bus.release_pulse, bus.long_pulse, bus.repeat_pulse});
         end
      end
   endtask
   task automatic test_press_release();
      bus.KEY = 4'b1110;
      for (int t = 1; t <= 10; t++) begin
         tick();
         vec++;
         if (bus.press_pulse !== ((t == 7) ? 4'b0001 : 4'b0000)) begin
            errs++;
            $display("FAIL press t=%0d: press_pulse=%b want %b", t, bus.press_pulse, (t == 7) ? 4'b0001 : 4'b0000);
         end
         vec++;
         if (bus.pressed !== ((t >= 7) ? 4'b0001 : 4'b0000)) begin
            errs++;
            $display("FAIL press_level t=%0d: pressed=%b want %b", t, bus.pressed, (t >= 7) ? 4'b0001 : 4'b0000);
         end
      end
      bus.KEY = 4'b1111;
      for (int t = 1; t <= 9; t++) begin
         tick();
         vec++;
         if (bus.release_pulse !== ((t == 7) ? 4'b0001 : 4'b0000)) begin
            errs++;
            $display("FAIL release t=%0d: release_pulse=%b want %b", t, bus.release_pulse, (t == 7) ? 4'b0001 : 4'b0000);
         end
         vec++;
         if (bus.pressed !== ((t < 7) ? 4'b0001 : 4'b0000)) begin
            errs++;
            $display("FAIL release_level t=%0d: pressed=%b want %b", t, bus.pressed, (t < 7) ? 4'b0001 : 4'b0000);
         end
      end
   endtask
   task automatic test_glitch();
      bus.KEY = 4'b1101;
      for (int t = 1; t <= 14; t++) begin
         tick();
         if (t == 3) bus.KEY = 4'b1111;
         vec++;
         if ({bus.pressed, bus.press_pulse, bus.release_pulse, bus.long_pulse, bus.repeat_pulse} !== 20'h0) begin
            errs++;
            $display("FAIL glitch t=%0d: outputs=%h want 0", t, {bus.pressed, bus.press_pulse, bus.release_pulse, bus.long_pulse, bus.repeat_pulse});
         end
      end
   endtask
   task automatic test_long_repeat();
      logic [3:0] ep, el, er, erel, elev;
      bus.KEY = 4'b1110;
      for (int t = 1; t <= 72; t++) begin
         tick();
         if (t == 60) bus.KEY = 4'b1111;
         ep   = {3'b0, t == 7};
         el   = {3'b0, t == 27};
         er   = {3'b0, (t >= 32) && (t <= 62) && ((t - 32) % 5 == 0)};
         erel = {3'b0, t == 67};
         elev = {3'b0, (t >= 7) && (t < 67)};
         vec++;
         if ({bus.press_pulse, bus.long_pulse, bus.repeat_pulse, bus.release_pulse, bus.pressed} !== {ep, el, er, erel, elev}) begin
            errs++;
            $display("FAIL long t=%0d: press/long/rep/rel/lvl=%b/%b/%b/%b/%b want %b/%b/%b/%b/%b", t,
                     bus.press_pulse, bus.long_pulse, bus.repeat_pulse, bus.release_pulse, bus.pressed, ep, el, er, erel, elev);
         end
      end
   endtask
   task automatic test_release_bounce();
      bus.KEY = 4'b1110;
      repeat (10) tick();
      vec++;
      if (bus.pressed !== 4'b0001) begin
         errs++;
         $display("FAIL bounce_pre: pressed=%b want 0001", bus.pressed);
      end
      bus.KEY = 4'b1111;
      for (int t = 1; t <= 14; t++) begin
         tick();
         bus.KEY = (t == 2) ? 4'b1110 : 4'b1111;
         vec++;
         if ({bus.release_pulse, bus.press_pulse, bus.pressed} !== {(t == 10) ? 4'b0001 : 4'b0000, 4'b0000, (t < 10) ? 4'b0001 : 4'b0000}) begin
            errs++;
            $display("FAIL bounce t=%0d: rel/press/lvl=%b/%b/%b want %b/0000/%b", t, bus.release_pulse, bus.press_pulse, bus.pressed,
                     (t == 10) ? 4'b0001 : 4'b0000, (t < 10) ? 4'b0001 : 4'b0000);
         end
      end
   endtask
   task automatic test_reset_mid_press();
      bus.KEY = 4'b1011;
      repeat (10) tick();
      vec++;
      if (bus.pressed !== 4'b0100) begin
         errs++;
         $display("FAIL midrst_pre: pressed=%b want 0100", bus.pressed);
      end
      RST_N = 1'b0;
      #1;
      vec++;
      if ({bus.pressed, bus.press_pulse, bus.release_pulse, bus.long_pulse, bus.repeat_pulse} !== 20'h0) begin
         errs++;
         $display("FAIL midrst_async: outputs=%h want 0", {bus.pressed, bus.press_pulse, bus.release_pulse, bus.long_pulse, bus.repeat_pulse});
      end
      for (int t = 1; t <= 3; t++) begin
         tick();
         vec++;
         if ({bus.pressed, bus.release_pulse} !== 8'h0) begin
            errs++;
            $display("FAIL midrst_hold t=%0d: pressed=%b release_pulse=%b want 0/0", t, bus.pressed, bus.release_pulse);
         end
      end
      RST_N = 1'b1;
      for (int t = 1; t <= 10; t++) begin
         tick();
         vec++;
         if ({bus.press_pulse, bus.release_pulse} !== {(t == 7) ? 4'b0100 : 4'b0000, 4'b0000}) begin
            errs++;
            $display("FAIL midrst_repress t=%0d: press=%b rel=%b want %b/0000", t, bus.press_pulse, bus.release_pulse,
                     (t == 7) ? 4'b0100 : 4'b0000);
         end
      end
      bus.KEY = 4'b1111;
      repeat (10) tick();
   endtask
   task automatic test_simultaneous();
      bus.KEY = 4'b0110;
      for (int t = 1; t <= 9; t++) begin
         tick();
         vec++;
         if (bus.press_pulse !== ((t == 7) ? 4'b1001 : 4'b0000)) begin
            errs++;
            $display("FAIL simul_press t=%0d: press_pulse=%b want %b", t, bus.press_pulse, (t == 7) ? 4'b1001 : 4'b0000);
         end
      end
      bus.KEY = 4'b1111;
      for (int t = 1; t <= 9; t++) begin
         tick();
         vec++;
         if ({bus.release_pulse, bus.press_pulse} !== {(t == 7) ? 4'b1001 : 4'b0000, 4'b0000}) begin
            errs++;
            $display("FAIL simul_release t=%0d: rel=%b press=%b want %b/0000", t, bus.release_pulse, bus.press_pulse,
                     (t == 7) ? 4'b1001 : 4'b0000);
         end
      end
   endtask
   initial begin
      bus.KEY = 4'b1111;
      test_reset();
      test_press_release();
      repeat (3) tick();
      test_glitch();
      test_long_repeat();
      repeat (3) tick();
      test_release_bounce();
      repeat (3) tick();
      test_reset_mid_press();
      test_simultaneous();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end
endmodule
